// File: rtl/shader_loader.sv
// SPI-slave programming port: deserialises host bytes and shifts them into shader_memory, padding short frames with NOPs.
// Optional readback of the displaced program on MISO when SHADER_LOADER_READBACK_EN is defined.
`timescale 1ns/1ps
module shader_loader #(
    parameter int         NUM_INSTR   = 16,
    parameter logic [7:0] NOP_INSTR   = 8'b01_00_00_00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    input  logic       spi_cs_ni,
    output logic       spi_miso_o,
    input  logic [7:0] mem_instr_i,
    output logic       shift_o,
    output logic       load_o,
    output logic [7:0] instr_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ovf_o
);
    localparam int WCW = $clog2(NUM_INSTR + 1);
    localparam logic [WCW-1:0] WFULL = WCW'(NUM_INSTR);

    typedef enum logic [1:0] {IDLE, RECV, PAD, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csn_sync;
    logic                   sclk_q, csn_q;
    logic                   sclk_s, mosi_s, csn_s;
    logic                   sclk_rise, cs_fall, cs_rise;

    logic [7:0]     shreg, instr_q, byte_nxt;
    logic [2:0]     bitcnt;
    logic [WCW-1:0] wcnt, wcnt_after;
    logic           shift_q, ovf_q, byte_done, commit, tx_msb;

    // Sync chains reset to 0 so a cs_n held low through reset never looks like a falling edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            csn_sync  <= '0;
            sclk_q    <= 1'b0;
            csn_q     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_cs_ni};
            sclk_q    <= sclk_s;
            csn_q     <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign cs_fall   = ~csn_s & csn_q;
    assign cs_rise   = csn_s & ~csn_q;

    assign byte_nxt   = {shreg[6:0], mosi_s};
    assign byte_done  = (state == RECV) && sclk_rise && (bitcnt == 3'd7);
    assign commit     = byte_done && (wcnt < WFULL);
    // A byte finishing alongside the cs_n rise counts toward the exit decision.
    assign wcnt_after = wcnt + {{(WCW-1){1'b0}}, commit};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cs_fall) state_nxt = RECV;
            RECV: begin
                if (cs_rise) begin
                    if (wcnt_after == '0)        state_nxt = IDLE;
                    else if (wcnt_after == WFULL) state_nxt = DONE;
                    else                          state_nxt = PAD;
                end
            end
            PAD:  if (wcnt == WFULL) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        spi_miso_o = 1'b0;
        case (state)
            RECV: begin
                busy_o     = 1'b1;
                spi_miso_o = tx_msb;
            end
            PAD:  busy_o = 1'b1;
            DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg   <= '0;
            instr_q <= '0;
            bitcnt  <= '0;
            wcnt    <= '0;
            shift_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bitcnt <= '0;
                        wcnt   <= '0;
                        ovf_q  <= 1'b0;
                    end
                end
                RECV: begin
                    if (sclk_rise) begin
                        shreg  <= byte_nxt;
                        bitcnt <= bitcnt + 3'd1;
                    end
                    if (commit) begin
                        shift_q <= 1'b1;
                        instr_q <= byte_nxt;
                        wcnt    <= wcnt + WCW'(1);
                    end else if (byte_done) begin
                        ovf_q <= 1'b1;
                    end
                    if (cs_rise) bitcnt <= '0;
                end
                PAD: begin
                    if (wcnt != WFULL) begin
                        shift_q <= 1'b1;
                        instr_q <= NOP_INSTR;
                        wcnt    <= wcnt + WCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign shift_o = shift_q;
    assign load_o  = shift_q;
    assign instr_o = instr_q;
    assign ovf_o   = ovf_q;

`ifdef SHADER_LOADER_READBACK_EN
    logic [7:0] tx_q;
    logic       shift_d, sclk_fall;

    assign sclk_fall = ~sclk_s & sclk_q;

    // Reload one cycle after a write pulse, once word 0 shows the next word to be displaced.
    // The fall following a byte's last bit is skipped so the fresh word is not shifted early.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_q    <= '0;
            shift_d <= 1'b0;
        end else begin
            shift_d <= shift_q;
            if ((state == IDLE && cs_fall) || (state == RECV && shift_d))
                tx_q <= mem_instr_i;
            else if (state == RECV && sclk_fall && bitcnt != 3'd0)
                tx_q <= {tx_q[6:0], 1'b0};
        end
    end

    assign tx_msb = tx_q[7];
`else
    logic unused_mem;
    assign unused_mem = ^mem_instr_i;
    assign tx_msb     = 1'b0;
`endif

endmodule

// File: tb/tb_shader_loader.sv
// Directed bench for shader_loader with a shift-register model of shader_memory.
`timescale 1ns/1ps
module tb_shader_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sclk, spi_mosi, spi_cs_n, spi_miso;
    logic       shift, load, busy, done, ovf;
    logic [7:0] instr, mem_word0;
    logic [7:0] mem [16];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   ld_err = 0;
    logic [7:0] pulses [$];
    int   pcyc [$];

    always #5 clk = ~clk;

    shader_loader dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .spi_sclk_i (spi_sclk),
        .spi_mosi_i (spi_mosi),
        .spi_cs_ni  (spi_cs_n),
        .spi_miso_o (spi_miso),
        .mem_instr_i(mem_word0),
        .shift_o    (shift),
        .load_o     (load),
        .instr_o    (instr),
        .busy_o     (busy),
        .done_o     (done),
        .ovf_o      (ovf)
    );

    // shader_memory model: words move toward 0, new word enters at the top
    always @(posedge clk) begin
        if (shift) begin
            for (int i = 0; i < 15; i++) mem[i] <= mem[i+1];
            mem[15] <= instr;
        end
    end
    assign mem_word0 = mem[0];

    always begin
        @(posedge clk);
        #2;
        if (shift) begin
            pulses.push_back(instr);
            pcyc.push_back(cyc);
        end
        if (load !== shift) ld_err++;
        if (done) n_done++;
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            tick(4);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            tick(4);
            spi_sclk = 1'b0;
        end
        tick(2);
    endtask

    task automatic clr();
        pulses.delete();
        pcyc.delete();
        n_done = 0;
    endtask

    task automatic frame_begin();
        clr();
        spi_cs_n = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        tick(4);
        spi_cs_n = 1'b1;
        tick(60);
    endtask

    function automatic logic [7:0] pul(input int i);
        return (i < pulses.size()) ? pulses[i] : 8'hxx;
    endfunction

    logic [7:0] rx, rx_or;
    logic [7:0] rb_exp [16];

    initial begin
        rst_n = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // reset with SPI noise
        for (int i = 0; i < 20; i++) begin
            tick(1);
            spi_sclk = 1'($urandom_range(0, 1));
            spi_mosi = 1'($urandom_range(0, 1));
            spi_cs_n = 1'($urandom_range(0, 1));
        end
        tick(1);
        chk("rst_shift", shift, 0);
        chk("rst_load", load, 0);
        chk("rst_instr", instr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_miso", spi_miso, 0);
        spi_sclk = 1'b0; spi_cs_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clr();
        tick(5);
        spi_bits(8'h55, 8, rx);
        tick(10);
        chk("low_cs_no_pulse", pulses.size(), 0);
        chk("low_cs_busy", busy, 0);
        spi_cs_n = 1'b1;
        tick(10);

        // full frame
        frame_begin();
        rx_or = '0;
        for (int i = 0; i < 16; i++) begin
            spi_bits(8'(i), 8, rx);
            rx_or |= rx;
        end
        frame_end();
        chk("full_cnt", pulses.size(), 16);
        for (int i = 0; i < 16; i++) chk("full_data", pul(i), 8'(i));
        chk("full_done", n_done, 1);
        chk("full_ovf", ovf, 0);
        chk("full_busy", busy, 0);
        chk("full_mem0", mem[0], 8'h00);
        chk("full_mem15", mem[15], 8'h0F);
        chk("instr_hold", instr, 8'h0F);
`ifndef SHADER_LOADER_READBACK_EN
        chk("miso_off", rx_or, 0);
`endif

        // short frame
        frame_begin();
        for (int i = 0; i < 5; i++) spi_bits(8'hA1 + 8'(i), 8, rx);
        frame_end();
        chk("short_cnt", pulses.size(), 16);
        chk("short_d4", pul(4), 8'hA5);
        chk("short_pad5", pul(5), 8'h40);
        chk("short_pad15", pul(15), 8'h40);
        chk("short_b2b", (pcyc.size() == 16) ? pcyc[15] - pcyc[5] : -1, 10);
        chk("short_done", n_done, 1);
        chk("short_mem0", mem[0], 8'hA1);
        chk("short_mem4", mem[4], 8'hA5);
        chk("short_mem5", mem[5], 8'h40);
        chk("short_mem15", mem[15], 8'h40);

        // empty frame
        frame_begin();
        tick(4);
        spi_cs_n = 1'b1;
        tick(30);
        chk("empty_cnt", pulses.size(), 0);
        chk("empty_done", n_done, 0);
        chk("empty_busy", busy, 0);

        // two bytes plus a partial byte
        frame_begin();
        spi_bits(8'h3C, 8, rx);
        spi_bits(8'hC3, 8, rx);
        spi_bits(8'hFF, 5, rx);
        frame_end();
        chk("part_cnt", pulses.size(), 16);
        chk("part_d0", pul(0), 8'h3C);
        chk("part_d1", pul(1), 8'hC3);
        chk("part_pad", pul(2), 8'h40);
        chk("part_done", n_done, 1);
        chk("part_mem1", mem[1], 8'hC3);
        chk("part_mem2", mem[2], 8'h40);

        // overflow
        frame_begin();
        for (int i = 0; i < 16; i++) spi_bits(8'h80 + 8'(i), 8, rx);
        chk("ovf_16", ovf, 0);
        spi_bits(8'hEE, 8, rx);
        chk("ovf_17", ovf, 1);
        spi_bits(8'hDD, 8, rx);
        frame_end();
        chk("ovf_cnt", pulses.size(), 16);
        chk("ovf_done", n_done, 1);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_mem0", mem[0], 8'h80);
        chk("ovf_mem15", mem[15], 8'h8F);

        // reset aborts a frame
        frame_begin();
        chk("ovf_clear", ovf, 0);
        for (int i = 0; i < 3; i++) spi_bits(8'h11 * 8'(i + 1), 8, rx);
        tick(4);
        chk("abort_cnt3", pulses.size(), 3);
        rst_n = 1'b0;
        tick(1);
        chk("abort_busy", busy, 0);
        chk("abort_shift", shift, 0);
        chk("abort_instr", instr, 0);
        tick(3);
        rst_n = 1'b1;
        tick(30);
        chk("abort_nopad", pulses.size(), 3);
        chk("abort_done", n_done, 0);
        spi_cs_n = 1'b1;
        tick(20);
        chk("abort_idle", pulses.size(), 3);

`ifdef SHADER_LOADER_READBACK_EN
        rb_exp = '{8'h10, 8'h15, 8'h74, 8'h1A, 8'h98, 8'h00, 8'h40, 8'h40,
                   8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        for (int i = 0; i < 16; i++) mem[i] = rb_exp[i];
        frame_begin();
        for (int i = 0; i < 16; i++) begin
            spi_bits(8'hFF, 8, rx);
            chk("readback", rx, rb_exp[i]);
        end
        frame_end();
        chk("rb_done", n_done, 1);
        chk("rb_mem15", mem[15], 8'hFF);
        chk("rb_miso_idle", spi_miso, 0);
`endif

        chk("load_eq_shift", ld_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
